// File: rtl/dsp_addsub_pkg.sv
// Shared constants and op encodings for the pipelined DSP add/subtract unit.
package dsp_addsub_pkg;

  localparam int SEG_W = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  function automatic int seg_count(input int width);
    return width / SEG_W;
  endfunction

endpackage

// File: rtl/dsp_addsub_seg.sv
// One registered 16-bit adder segment: x + y + ci, captured when en is high.
// Maps onto an SB_MAC16 in adder-only mode; the behavioural model is used otherwise.
module dsp_addsub_seg
  import dsp_addsub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEG_W-1:0] x,
  input  logic [SEG_W-1:0] y,
  input  logic             ci,
  output logic [SEG_W-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

`ifdef SYNTHESIS
  logic [31:0] mac_o;
  logic        mac_co;
  logic        msb_xy;
  logic        live;

  SB_MAC16 #(
    .MODE_8x8              (1'b1),
    .A_SIGNED              (1'b0),
    .B_SIGNED              (1'b0),
    .TOPOUTPUT_SELECT      (2'b01),
    .TOPADDSUB_LOWERINPUT  (2'b00),
    .TOPADDSUB_UPPERINPUT  (1'b1),
    .TOPADDSUB_CARRYSELECT (2'b11),
    .BOTOUTPUT_SELECT      (2'b00),
    .BOTADDSUB_LOWERINPUT  (2'b00),
    .BOTADDSUB_UPPERINPUT  (1'b0),
    .BOTADDSUB_CARRYSELECT (2'b00)
  ) u_mac (
    .CLK(clk), .CE(en), .C(x), .A(y), .B(16'h0000), .D(16'h0000),
    .AHOLD(1'b0), .BHOLD(1'b0), .CHOLD(1'b0), .DHOLD(1'b0),
    .IRSTTOP(rst), .IRSTBOT(rst), .ORSTTOP(rst), .ORSTBOT(rst),
    .OLOADTOP(1'b0), .OLOADBOT(1'b0), .ADDSUBTOP(1'b0), .ADDSUBBOT(1'b0),
    .OHOLDTOP(1'b0), .OHOLDBOT(1'b0), .CI(ci), .ACCUMCI(1'b0), .SIGNEXTIN(1'b0),
    .O(mac_o), .CO(mac_co), .ACCUMCO(), .SIGNEXTOUT()
  );

  // Fabric side-band: MSB operand parity for overflow, and a flag keeping zero low after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      msb_xy <= 1'b0;
      live   <= 1'b0;
    end else if (en) begin
      msb_xy <= x[SEG_W-1] ^ y[SEG_W-1];
      live   <= 1'b1;
    end
  end

  assign sum  = mac_o[31:16];
  assign co   = mac_co;
  assign ovf  = msb_xy ^ sum[SEG_W-1] ^ mac_co;
  assign zero = live & ~|sum;
`else
  logic [SEG_W:0] full;
  logic           msb_cin;

  always_comb begin
    full    = {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, ci};
    msb_cin = x[SEG_W-1] ^ y[SEG_W-1] ^ full[SEG_W-1];
  end

  // Segment output register; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      co   <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (en) begin
      sum  <= full[SEG_W-1:0];
      co   <= full[SEG_W];
      ovf  <= msb_cin ^ full[SEG_W];
      zero <= ~|full[SEG_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/dsp_addsub_pipe.sv
// Pipelined add/sub/accumulate unit: one 16-bit segment resolved per stage with the
// carry rippled stage to stage, valid/ready handshake, global stall and accumulator.
module dsp_addsub_pipe
  import dsp_addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NSEG = seg_count(WIDTH);

  logic             advance, accept, xfer, acc_block;
  logic             cin0, is_acc;
  logic [WIDTH-1:0] opx, opy, acc;
  logic [NSEG-1:0]  vld, tag;
  logic [NSEG-1:0]  seg_ci, seg_co, seg_z;
  logic             seg_ovf [NSEG];
  logic [SEG_W-1:0] seg_x [NSEG];
  logic [SEG_W-1:0] seg_y [NSEG];
  logic [SEG_W-1:0] seg_sum [NSEG];
  // ska/skb[k][j]: operand segment j (j > k) travelling alongside stage k.
  // lo[k][j]: finished result segment j (j < k) aligned with stage k; lz[k]: all of them zero.
  logic [SEG_W-1:0] ska [NSEG][NSEG];
  logic [SEG_W-1:0] skb [NSEG][NSEG];
  logic [SEG_W-1:0] lo  [NSEG][NSEG];
  logic             lz  [NSEG];

  assign advance   = !out_valid || out_ready;
  assign acc_block = is_acc && (|(vld & tag));
  assign in_ready  = !rst && advance && !acc_block;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_valid = vld[NSEG-1];

  // Operand selection: SUB inverts B with carry-in 1, ACC adds a to acc, LOAD passes a.
  always_comb begin
    opx    = a;
    opy    = b;
    cin0   = 1'b0;
    is_acc = 1'b0;
    case (op)
      OP_ADD:  cin0 = 1'b0;
      OP_SUB:  begin opy = ~b; cin0 = 1'b1; end
      OP_ACC:  begin opx = acc; opy = a; is_acc = 1'b1; end
      OP_LOAD: begin opy = '0; is_acc = 1'b1; end
      default: cin0 = 1'b0;
    endcase
  end

  // Segment inputs: stage 0 from the operand mux, later stages from the skew registers.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg_x[k]  = '0;
      seg_y[k]  = '0;
      seg_ci[k] = 1'b0;
    end
    seg_x[0]  = opx[SEG_W-1:0];
    seg_y[0]  = opy[SEG_W-1:0];
    seg_ci[0] = cin0;
    for (int k = 1; k < NSEG; k++) begin
      seg_x[k]  = ska[k-1][k];
      seg_y[k]  = skb[k-1][k];
      seg_ci[k] = seg_co[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    dsp_addsub_seg u_seg (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .x    (seg_x[k]),
      .y    (seg_y[k]),
      .ci   (seg_ci[k]),
      .sum  (seg_sum[k]),
      .co   (seg_co[k]),
      .ovf  (seg_ovf[k]),
      .zero (seg_z[k])
    );
  end

  // Valid/tag shift chain; tag marks beats that will write acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      tag <= '0;
    end else if (advance) begin
      vld[0] <= accept;
      tag[0] <= is_acc;
      for (int k = 1; k < NSEG; k++) begin
        vld[k] <= vld[k-1];
        tag[k] <= tag[k-1];
      end
    end
  end

  // Skew (upper operands) and de-skew (lower results) registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        lz[k] <= 1'b0;
        for (int j = 0; j < NSEG; j++) begin
          ska[k][j] <= '0;
          skb[k][j] <= '0;
          lo[k][j]  <= '0;
        end
      end
    end else if (advance) begin
      for (int j = 1; j < NSEG; j++) begin
        ska[0][j] <= opx[j*SEG_W +: SEG_W];
        skb[0][j] <= opy[j*SEG_W +: SEG_W];
      end
      for (int k = 1; k < NSEG; k++) begin
        for (int j = k + 1; j < NSEG; j++) begin
          ska[k][j] <= ska[k-1][j];
          skb[k][j] <= skb[k-1][j];
        end
        for (int j = 0; j < k - 1; j++) begin
          lo[k][j] <= lo[k-1][j];
        end
        lo[k][k-1] <= seg_sum[k-1];
        lz[k]      <= (k == 1) ? seg_z[0] : (lz[k-1] & seg_z[k-1]);
      end
    end
  end

  // Accumulator commits only when an ACC/LOAD result is handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (xfer && tag[NSEG-1]) begin
      acc <= result;
    end
  end

  always_comb begin
    result = '0;
    for (int j = 0; j < NSEG - 1; j++) begin
      result[j*SEG_W +: SEG_W] = lo[NSEG-1][j];
    end
    result[(NSEG-1)*SEG_W +: SEG_W] = seg_sum[NSEG-1];
  end

  assign carry    = seg_co[NSEG-1];
  assign overflow = seg_ovf[NSEG-1];
  assign zero     = (NSEG == 1) ? seg_z[0] : (seg_z[NSEG-1] & lz[NSEG-1]);

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Directed self-checking bench for dsp_addsub_pipe at WIDTH=32 and WIDTH=64.
module tb_dsp_addsub_pipe;
  import dsp_addsub_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0, b = 32'h0, result;
  logic        carry, overflow, zero;
  logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b1;
  logic [1:0]  op64 = 2'b00;
  logic [63:0] a64 = 64'h0, b64 = 64'h0, result64;
  logic        carry64, overflow64, zero64;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dsp_addsub_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero)
  );

  dsp_addsub_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .op(op64), .a(a64), .b(b64),
    .out_valid(out_valid64), .out_ready(out_ready64), .result(result64), .carry(carry64),
    .overflow(overflow64), .zero(zero64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = v; op = o; a = x; b = y;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if ({carry, overflow, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {carry, overflow, zero}); end
    checks++; if (dut32.acc !== 32'h0) begin errors++; $display("FAIL reset_acc got=%h exp=0", dut32.acc); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_carry();
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'h0000_FFFF, 32'h0000_0001);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 32'h0001_0000) begin errors++; $display("FAIL add_result got=%h exp=00010000", result); end
    checks++; if ({carry, overflow, zero} !== 3'b000) begin errors++; $display("FAIL add_flags got=%b exp=000", {carry, overflow, zero}); end
    tick(); tick();
  endtask

  task automatic test_sub();
    drive(1'b1, OP_SUB, 32'h8000_0000, 32'h0000_0001);
    tick();
    drive(1'b1, OP_SUB, 32'h0000_0005, 32'h0000_0005);
    tick();
    in_valid = 1'b0;
    checks++; if (result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_ovf_result got=%h exp=7fffffff", result); end
    checks++; if ({out_valid, carry, overflow, zero} !== 4'b1110) begin errors++; $display("FAIL sub_ovf_flags got=%b exp=1110", {out_valid, carry, overflow, zero}); end
    tick();
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL sub_zero_result got=%h exp=0", result); end
    checks++; if ({out_valid, carry, overflow, zero} !== 4'b1101) begin errors++; $display("FAIL sub_zero_flags got=%b exp=1101", {out_valid, carry, overflow, zero}); end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    tick();
    drive(1'b1, OP_ADD, 32'd2, 32'd2);
    tick();
    drive(1'b1, OP_ADD, 32'd3, 32'd3);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    checks++; if ({out_valid, result} !== {1'b1, 32'd2}) begin errors++; $display("FAIL stall_first got=%b/%0d exp=1/2", out_valid, result); end
    tick();
    checks++; if ({out_valid, result} !== {1'b1, 32'd2}) begin errors++; $display("FAIL stall_hold got=%b/%0d exp=1/2", out_valid, result); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, result} !== {1'b1, 32'd4}) begin errors++; $display("FAIL b2b_second got=%b/%0d exp=1/4", out_valid, result); end
    tick();
    checks++; if ({out_valid, result} !== {1'b1, 32'd6}) begin errors++; $display("FAIL b2b_third got=%b/%0d exp=1/6", out_valid, result); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    tick();
  endtask

  task automatic test_acc();
    out_ready = 1'b1;
    drive(1'b1, OP_LOAD, 32'd10, 32'hDEAD_BEEF);
    tick();
    drive(1'b1, OP_ACC, 32'd5, 32'hDEAD_BEEF);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL acc_block_s0 got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL acc_block_s1 got=%b exp=0", in_ready); end
    checks++; if ({out_valid, result} !== {1'b1, 32'd10}) begin errors++; $display("FAIL load_result got=%b/%0d exp=1/10", out_valid, result); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL acc_unblock got=%b exp=1", in_ready); end
    checks++; if (dut32.acc !== 32'd10) begin errors++; $display("FAIL acc_after_load got=%0d exp=10", dut32.acc); end
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if ({out_valid, result} !== {1'b1, 32'd15}) begin errors++; $display("FAIL acc_result got=%b/%0d exp=1/15", out_valid, result); end
    tick();
    checks++; if (dut32.acc !== 32'd15) begin errors++; $display("FAIL acc_value got=%0d exp=15", dut32.acc); end
    drive(1'b1, OP_ACC, 32'hFFFF_FFF1, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL acc_wrap_result got=%h exp=0", result); end
    checks++; if ({out_valid, carry, overflow, zero} !== 4'b1101) begin errors++; $display("FAIL acc_wrap_flags got=%b exp=1101", {out_valid, carry, overflow, zero}); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, OP_LOAD, 32'h0000_1234, 32'h0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (dut32.acc !== 32'h0000_1234) begin errors++; $display("FAIL pre_reset_acc got=%h exp=00001234", dut32.acc); end
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd100, 32'd1);
    tick();
    drive(1'b1, OP_ADD, 32'd200, 32'd1);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dut32.acc !== 32'h0) begin errors++; $display("FAIL mid_reset_acc got=%h exp=0", dut32.acc); end
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_stale got=%b exp=0", out_valid); end
    drive(1'b1, OP_ADD, 32'd3, 32'd4);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if ({out_valid, result} !== {1'b1, 32'd7}) begin errors++; $display("FAIL post_reset_add got=%b/%0d exp=1/7", out_valid, result); end
    tick(); tick();
  endtask

  task automatic test_wide64();
    out_ready64 = 1'b1;
    in_valid64 = 1'b1; op64 = OP_ADD; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h1;
    #1;
    checks++; if (in_ready64 !== 1'b1) begin errors++; $display("FAIL w64_in_ready got=%b exp=1", in_ready64); end
    tick();
    op64 = OP_SUB; a64 = 64'h0; b64 = 64'h1;
    tick();
    in_valid64 = 1'b0;
    tick();
    checks++; if (out_valid64 !== 1'b0) begin errors++; $display("FAIL w64_latency_early got=%b exp=0", out_valid64); end
    tick();
    checks++; if (result64 !== 64'h0) begin errors++; $display("FAIL w64_add_result got=%h exp=0", result64); end
    checks++; if ({out_valid64, carry64, overflow64, zero64} !== 4'b1101) begin errors++; $display("FAIL w64_add_flags got=%b exp=1101", {out_valid64, carry64, overflow64, zero64}); end
    tick();
    checks++; if (result64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL w64_sub_result got=%h exp=ffffffffffffffff", result64); end
    checks++; if ({out_valid64, carry64, overflow64, zero64} !== 4'b1000) begin errors++; $display("FAIL w64_sub_flags got=%b exp=1000", {out_valid64, carry64, overflow64, zero64}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_acc();
    test_reset_mid();
    test_wide64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
